pkt_header_parser: RTL and testbench

Fetches the 8-byte header of a received packet from the byte-wide packet memory and assembles it into four 16-bit fields: packet type, source ID, destination ID and hop count. Sits directly upstream of the destination-check stage. Its `destination_id` output drives that stage's `destinationID` input, and its `done` gates that stage's `en`. The parser also flags malformed headers, so downstream stages can discard the packet without further processing.

---
 rtl/pkt_header_parser.sv | 144 ++++++++++++++
 tb/tb_pkt_header_parser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_header_parser.sv
// pkt_header_parser: fetches the 8-byte big-endian packet header from
// byte-wide synchronous memory and splits it into four checked fields.
module pkt_header_parser #(
  parameter int ADDR_WIDTH = 11,
  parameter int MEM_WIDTH  = 8,
  parameter int WORD_WIDTH = 16,
  parameter int MAX_TYPE   = 4,
  parameter int MAX_HOPS   = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [MEM_WIDTH-1:0]  mem_data_in,
  output logic [WORD_WIDTH-1:0] pkt_type,
  output logic [WORD_WIDTH-1:0] source_id,
  output logic [WORD_WIDTH-1:0] destination_id,
  output logic [WORD_WIDTH-1:0] hop_count,
  output logic                  hdr_valid,
  output logic                  hdr_error,
  output logic                  done
);

  localparam int NB = 4 * WORD_WIDTH / MEM_WIDTH;
  localparam int IW = $clog2(NB);
  localparam int HW = NB * MEM_WIDTH;
  localparam logic [WORD_WIDTH-1:0] MAX_T = WORD_WIDTH'(MAX_TYPE);
  localparam logic [WORD_WIDTH-1:0] MAX_H = WORD_WIDTH'(MAX_HOPS);

  typedef enum logic [2:0] {
    IDLE, ARMED, READ, DRAIN, CHECK, DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         cap_idx_q;
  logic                  cap_vld_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [HW-1:0]         hdr_q;
  logic                  last_rd;
  logic                  bad;
  logic                  clr, load, issue, chk;

  assign last_rd = (idx_q == IW'(NB - 1));

  assign pkt_type       = hdr_q[HW-1 -: WORD_WIDTH];
  assign source_id      = hdr_q[HW-1-WORD_WIDTH -: WORD_WIDTH];
  assign destination_id = hdr_q[HW-1-2*WORD_WIDTH -: WORD_WIDTH];
  assign hop_count      = hdr_q[WORD_WIDTH-1:0];

  assign bad = (pkt_type == '0) || (pkt_type > MAX_T) ||
               (hop_count > MAX_H);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (start) state_d = READ;
        READ:    if (last_rd) state_d = DRAIN;
        DRAIN:   state_d = CHECK;
        CHECK:   state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    clr   = 1'b0;
    load  = 1'b0;
    issue = 1'b0;
    chk   = 1'b0;
    unique case (1'b1)
      en:                                clr   = 1'b1;
      !en && state_q == ARMED && start:  load  = 1'b1;
      !en && state_q == READ:            issue = 1'b1;
      !en && state_q == CHECK:           chk   = 1'b1;
      default: ;
    endcase
  end

  // Read data lags the strobe by one cycle, so the byte index rides
  // along in cap_idx_q to steer the write into the header register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      hdr_q     <= '0;
      hdr_valid <= 1'b0;
      hdr_error <= 1'b0;
      done      <= 1'b0;
    end else if (clr) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      idx_q     <= '0;
      cap_vld_q <= 1'b0;
      hdr_q     <= '0;
      hdr_valid <= 1'b0;
      hdr_error <= 1'b0;
      done      <= 1'b0;
    end else begin
      cap_vld_q <= mem_rd_en;
      cap_idx_q <= idx_q;
      if (cap_vld_q)
        hdr_q[(NB-1-int'(cap_idx_q))*MEM_WIDTH +: MEM_WIDTH] <=
          mem_data_in;
      if (load) begin
        base_q    <= base_addr;
        idx_q     <= '0;
        mem_addr  <= base_addr;
        mem_rd_en <= 1'b1;
      end else if (issue) begin
        if (last_rd) begin
          mem_rd_en <= 1'b0;
        end else begin
          idx_q    <= idx_q + IW'(1);
          mem_addr <= base_q + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
        end
      end
      if (chk) begin
        hdr_error <= bad;
        hdr_valid <= !bad;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_header_parser.sv
// tb_pkt_header_parser: scoreboard bench for the header parser with a
// behavioural synchronous byte memory.
module tb_pkt_header_parser;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [10:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data_in = '0;
  logic [15:0] pkt_type, source_id, destination_id, hop_count;
  logic        hdr_valid, hdr_error, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [63:0] hdr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] addr_q[$];
  logic [7:0]  mem [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_data_in <= mem[mem_addr];

  pkt_header_parser dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start),
    .base_addr(base_addr), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_data_in(mem_data_in),
    .pkt_type(pkt_type), .source_id(source_id),
    .destination_id(destination_id), .hop_count(hop_count),
    .hdr_valid(hdr_valid), .hdr_error(hdr_error), .done(done)
  );

  task automatic run_parse(input string nm, input logic [10:0] base,
                           input logic [63:0] h, input bit do_en,
                           input bit hold_start);
    exp_t e;
    logic [10:0] a;
    logic [10:0] ea;
    int cyc;
    int nrd;
    for (int k = 0; k < 8; k++) begin
      a = base + 11'(k);
      mem[a] = h[63-8*k -: 8];
      addr_q.push_back(a);
    end
    e.hdr = h;
    e.err = (h[63:48] == 16'd0) || (h[63:48] > 16'd4) ||
            (h[15:0] > 16'd16);
    exp_q.push_back(e);
    if (do_en) begin
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
    end
    start = 1'b1;
    base_addr = base;
    @(posedge clk);
    cyc = 0;
    nrd = 0;
    while (1) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      base_addr = ~base;
      if (mem_rd_en) begin
        nrd++;
        ea = (addr_q.size() > 0) ? addr_q.pop_front() : 11'h0;
        vectors++;
        if (mem_addr !== ea) begin
          miscompares++;
          $display("FAIL %s addr[%0d]: got %h want %h",
                   nm, nrd - 1, mem_addr, ea);
        end
      end
      if (done || cyc >= 30) break;
      @(posedge clk);
      cyc++;
    end
    addr_q.delete();
    vectors++;
    if (cyc !== 10) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want 10", nm, cyc);
    end
    vectors++;
    if (nrd !== 8) begin
      miscompares++;
      $display("FAIL %s reads: got %0d want 8", nm, nrd);
    end
    e = exp_q.pop_front();
    vectors++;
    if ({pkt_type, source_id, destination_id, hop_count} !== e.hdr) begin
      miscompares++;
      $display("FAIL %s fields: got %h_%h_%h_%h want %h", nm, pkt_type,
               source_id, destination_id, hop_count, e.hdr);
    end
    vectors++;
    if ({hdr_error, hdr_valid} !== {e.err, !e.err}) begin
      miscompares++;
      $display("FAIL %s flags err/val: got %b%b want %b%b", nm,
               hdr_error, hdr_valid, e.err, !e.err);
    end
  endtask

  // Arms, starts, and returns at the negedge showing the 4th read.
  task automatic start_partial(input logic [10:0] base);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    start = 1'b1;
    base_addr = base;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    vectors++;
    if ({mem_rd_en, mem_addr, pkt_type, source_id, destination_id,
         hop_count, hdr_valid, hdr_error, done} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: rd=%b addr=%h hdr=%h_%h_%h_%h v=%b e=%b d=%b want all 0",
               nm, mem_rd_en, mem_addr, pkt_type, source_id,
               destination_id, hop_count, hdr_valid, hdr_error, done);
    end
  endtask

  task automatic check_no_reads(input string nm, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (mem_rd_en) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL %s: got %0d read cycles want 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    run_parse("basic_err", 11'h100, 64'h0100_002A_0007_0003, 1, 0);
    run_parse("basic_ok", 11'h100, 64'h0002_002A_0007_0003, 1, 0);
  endtask

  task automatic test_wrap();
    run_parse("wrap", 11'h7FD, 64'h0003_BEEF_1234_000A, 1, 0);
  endtask

  task automatic test_boundaries();
    run_parse("hop16", 11'h200, 64'h0001_0011_0022_0010, 1, 0);
    run_parse("hop17", 11'h208, 64'h0001_0011_0022_0011, 1, 0);
    run_parse("type0", 11'h210, 64'h0000_0011_0022_0001, 1, 0);
    run_parse("type4", 11'h218, 64'h0004_0011_0022_0001, 1, 0);
    run_parse("type5", 11'h220, 64'h0005_0011_0022_0001, 1, 0);
  endtask

  task automatic test_abort();
    start_partial(11'h300);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    check_zero("abort");
    check_no_reads("abort_noreads", 4);
    run_parse("after_abort", 11'h308, 64'h0002_0A0B_0C0D_0005, 0, 0);
  endtask

  task automatic test_reset_mid();
    start_partial(11'h400);
    nrst = 1'b0;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    nrst = 1'b1;
    start = 1'b1;
    check_no_reads("start_in_idle", 12);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_idle done: got %b want 0", done);
    end
  endtask

  task automatic test_handshake();
    int bad;
    run_parse("hold_start", 11'h500, 64'h0003_0001_0002_0003, 1, 1);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_rd_en || !done) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL hold_done: got %0d bad cycles want 0", bad);
    end
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    start = 1'b0;
    check_zero("en_start_done");
    check_no_reads("armed_idle", 3);
    run_parse("back_to_back", 11'h508, 64'h0001_7777_8888_0000, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_boundaries();
    test_abort();
    test_reset_mid();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
